// File: rtl/control_pipeline_if.sv
// Decoder-side control bundle in, per-stage controls out.
// Master drives ID controls, slave returns staged controls.
interface control_pipeline_if #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
);
  logic               RegDst;
  logic               Branch;
  logic               MemRead;
  logic               MemtoReg;
  logic [ALUOP_W-1:0] ALUOp;
  logic               MemWrite;
  logic               ALUSrc;
  logic               RegWrite;
  logic [REG_W-1:0]   IdRs;
  logic [REG_W-1:0]   IdRt;
  logic [REG_W-1:0]   IdRd;
  logic               ExZero;
  logic               ExRegDst;
  logic [ALUOP_W-1:0] ExALUOp;
  logic               ExALUSrc;
  logic               MemMemRead;
  logic               MemMemWrite;
  logic               PCSrc;
  logic               WbRegWrite;
  logic               WbMemtoReg;
  logic [REG_W-1:0]   WbWriteReg;
  logic               Stall;
  logic               FlushIfId;

  modport master (
    output RegDst, Branch, MemRead, MemtoReg,
    output ALUOp, MemWrite, ALUSrc, RegWrite,
    output IdRs, IdRt, IdRd, ExZero,
    input  ExRegDst, ExALUOp, ExALUSrc,
    input  MemMemRead, MemMemWrite, PCSrc,
    input  WbRegWrite, WbMemtoReg, WbWriteReg,
    input  Stall, FlushIfId
  );

  modport slave (
    input  RegDst, Branch, MemRead, MemtoReg,
    input  ALUOp, MemWrite, ALUSrc, RegWrite,
    input  IdRs, IdRt, IdRd, ExZero,
    output ExRegDst, ExALUOp, ExALUSrc,
    output MemMemRead, MemMemWrite, PCSrc,
    output WbRegWrite, WbMemtoReg, WbWriteReg,
    output Stall, FlushIfId
  );
endinterface

// File: rtl/control_pipeline.sv
// Control bundle pipeline ID/EX -> EX/MEM -> MEM/WB with
// load-use stall, branch resolution in MEM and flush.
module control_pipeline #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
) (
  input  logic Clk,
  input  logic Rst,
  control_pipeline_if.slave bus
);

  typedef struct packed {
    logic               reg_dst;
    logic               branch;
    logic               mem_read;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
  } id_ex_t;

  typedef struct packed {
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] dest;
    logic             zero;
  } ex_mem_t;

  typedef struct packed {
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] dest;
  } mem_wb_t;

  id_ex_t  id_ex, id_ex_n;
  ex_mem_t ex_mem, ex_mem_n;
  mem_wb_t mem_wb, mem_wb_n;

  logic             pc_src;
  logic             stall;
  logic             bubble;
  logic             rt_hit;
  logic [REG_W-1:0] dest_ex;

  assign pc_src  = ex_mem.branch & ex_mem.zero;
  assign rt_hit  = (id_ex.rt == bus.IdRs) |
                   (id_ex.rt == bus.IdRt);
  // A taken branch kills the ID instruction anyway,
  // so the flush takes precedence over the stall.
  assign stall   = id_ex.mem_read & (|id_ex.rt) &
                   rt_hit & ~pc_src;
  assign bubble  = stall | pc_src;
  assign dest_ex = id_ex.reg_dst ? id_ex.rd : id_ex.rt;

  always_comb begin
    id_ex_n            = '0;
    id_ex_n.rt         = bus.IdRt;
    id_ex_n.rd         = bus.IdRd;
    if (!bubble) begin
      id_ex_n.reg_dst    = bus.RegDst;
      id_ex_n.branch     = bus.Branch;
      id_ex_n.mem_read   = bus.MemRead;
      id_ex_n.mem_to_reg = bus.MemtoReg;
      id_ex_n.alu_op     = bus.ALUOp;
      id_ex_n.mem_write  = bus.MemWrite;
      id_ex_n.alu_src    = bus.ALUSrc;
      id_ex_n.reg_write  = bus.RegWrite;
    end
  end

  always_comb begin
    ex_mem_n      = '0;
    ex_mem_n.dest = dest_ex;
    ex_mem_n.zero = bus.ExZero;
    if (!pc_src) begin
      ex_mem_n.branch     = id_ex.branch;
      ex_mem_n.mem_read   = id_ex.mem_read;
      ex_mem_n.mem_write  = id_ex.mem_write;
      ex_mem_n.mem_to_reg = id_ex.mem_to_reg;
      ex_mem_n.reg_write  = id_ex.reg_write;
    end
  end

  // The branch itself sits in MEM and must still commit.
  always_comb begin
    mem_wb_n            = '0;
    mem_wb_n.mem_to_reg = ex_mem.mem_to_reg;
    mem_wb_n.reg_write  = ex_mem.reg_write;
    mem_wb_n.dest       = ex_mem.dest;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      id_ex  <= id_ex_n;
      ex_mem <= ex_mem_n;
      mem_wb <= mem_wb_n;
    end
  end

  assign bus.ExRegDst    = id_ex.reg_dst;
  assign bus.ExALUOp     = id_ex.alu_op;
  assign bus.ExALUSrc    = id_ex.alu_src;
  assign bus.MemMemRead  = ex_mem.mem_read;
  assign bus.MemMemWrite = ex_mem.mem_write;
  assign bus.PCSrc       = pc_src;
  assign bus.WbRegWrite  = mem_wb.reg_write;
  assign bus.WbMemtoReg  = mem_wb.mem_to_reg;
  assign bus.WbWriteReg  = mem_wb.dest;
  assign bus.Stall       = stall;
  assign bus.FlushIfId   = pc_src;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed stimulus with a cycle-tagged expectation queue
// drained by an independent negedge monitor.
module tb_control_pipeline;

  logic Clk;
  logic Rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  control_pipeline_if #(.REG_W(5), .ALUOP_W(2)) bus ();

  control_pipeline #(.REG_W(5), .ALUOP_W(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  typedef enum int {
    S_EXREGDST, S_EXALUOP, S_EXALUSRC, S_MEMRD, S_MEMWR,
    S_PCSRC, S_WBRW, S_WBM2R, S_WBREG, S_STALL, S_FLUSH,
    S_NUM
  } sig_e;

  typedef struct {
    int    due;
    sig_e  id;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  string cur_tag;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int sig(sig_e s);
    case (s)
      S_EXREGDST: return int'(bus.ExRegDst);
      S_EXALUOP:  return int'(bus.ExALUOp);
      S_EXALUSRC: return int'(bus.ExALUSrc);
      S_MEMRD:    return int'(bus.MemMemRead);
      S_MEMWR:    return int'(bus.MemMemWrite);
      S_PCSRC:    return int'(bus.PCSrc);
      S_WBRW:     return int'(bus.WbRegWrite);
      S_WBM2R:    return int'(bus.WbMemtoReg);
      S_WBREG:    return int'(bus.WbWriteReg);
      S_STALL:    return int'(bus.Stall);
      S_FLUSH:    return int'(bus.FlushIfId);
      default:    return -1;
    endcase
  endfunction

  function automatic logic known(sig_e s);
    case (s)
      S_EXREGDST: return !$isunknown(bus.ExRegDst);
      S_EXALUOP:  return !$isunknown(bus.ExALUOp);
      S_EXALUSRC: return !$isunknown(bus.ExALUSrc);
      S_MEMRD:    return !$isunknown(bus.MemMemRead);
      S_MEMWR:    return !$isunknown(bus.MemMemWrite);
      S_PCSRC:    return !$isunknown(bus.PCSrc);
      S_WBRW:     return !$isunknown(bus.WbRegWrite);
      S_WBM2R:    return !$isunknown(bus.WbMemtoReg);
      S_WBREG:    return !$isunknown(bus.WbWriteReg);
      S_STALL:    return !$isunknown(bus.Stall);
      S_FLUSH:    return !$isunknown(bus.FlushIfId);
      default:    return 1'b0;
    endcase
  endfunction

  always @(negedge Clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        n_cmp++;
        if (sb[i].due < cyc) begin
          n_bad++;
          $display("FAIL %s/%s: expired at cyc %0d",
                   sb[i].tag, sb[i].id.name(), cyc);
        end else if (!known(sb[i].id) ||
                     sig(sb[i].id) != sb[i].val) begin
          n_bad++;
          $display("FAIL %s/%s cyc %0d: got %0d want %0d",
                   sb[i].tag, sb[i].id.name(), cyc,
                   sig(sb[i].id), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp(input int off, input sig_e s,
                     input int v);
    exp_t e;
    e.due = cyc + off;
    e.id  = s;
    e.val = v;
    e.tag = cur_tag;
    sb.push_back(e);
  endtask

  task automatic exp_all_zero(input int off);
    for (int s = 0; s < int'(S_NUM); s++)
      exp(off, sig_e'(s), 0);
  endtask

  task automatic drive(
    input logic rd, br, mr, m2r,
    input logic [1:0] aop,
    input logic mw, as, rw,
    input logic [4:0] rs, rt, rdf
  );
    bus.RegDst   = rd;
    bus.Branch   = br;
    bus.MemRead  = mr;
    bus.MemtoReg = m2r;
    bus.ALUOp    = aop;
    bus.MemWrite = mw;
    bus.ALUSrc   = as;
    bus.RegWrite = rw;
    bus.IdRs     = rs;
    bus.IdRt     = rt;
    bus.IdRd     = rdf;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic rtype(input logic [4:0] rs, rt, rdf);
    drive(1, 0, 0, 0, 2'b10, 0, 0, 1, rs, rt, rdf);
  endtask

  task automatic lw(input logic [4:0] rs, rt);
    drive(0, 0, 1, 1, 2'b00, 0, 1, 1, rs, rt, 5'd0);
  endtask

  task automatic sw(input logic [4:0] rs, rt);
    drive(0, 0, 0, 0, 2'b00, 1, 1, 0, rs, rt, 5'd0);
  endtask

  task automatic beq(input logic [4:0] rs, rt);
    drive(0, 1, 0, 0, 2'b01, 0, 0, 0, rs, rt, 5'd0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input int n);
    nop();
    repeat (n) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.ExZero = 1'b0;

    cur_tag = "reset";
    Rst = 1'b1;
    rtype(5'd1, 5'd2, 5'd5);
    tick();
    exp_all_zero(0);
    tick();
    exp_all_zero(0);
    cur_tag = "rtype";
    Rst = 1'b0;
    exp(1, S_EXREGDST, 1);
    exp(1, S_EXALUOP, 2);
    exp(1, S_EXALUSRC, 0);
    exp(3, S_WBRW, 1);
    exp(3, S_WBREG, 5);
    exp(3, S_WBM2R, 0);
    tick();
    drain(3);

    cur_tag = "lw_sw";
    lw(5'd1, 5'd8);
    exp(1, S_EXALUSRC, 1);
    exp(2, S_MEMRD, 1);
    exp(2, S_MEMWR, 0);
    exp(3, S_WBM2R, 1);
    exp(3, S_WBREG, 8);
    exp(3, S_WBRW, 1);
    tick();
    sw(5'd2, 5'd9);
    exp(0, S_STALL, 0);
    exp(2, S_MEMWR, 1);
    exp(2, S_MEMRD, 0);
    exp(3, S_WBRW, 0);
    tick();
    drain(4);

    cur_tag = "loaduse";
    lw(5'd1, 5'd8);
    tick();
    rtype(5'd8, 5'd3, 5'd10);
    exp(0, S_STALL, 1);
    exp(1, S_STALL, 0);
    exp(1, S_EXREGDST, 0);
    exp(1, S_EXALUOP, 0);
    exp(1, S_EXALUSRC, 0);
    exp(2, S_MEMRD, 0);
    tick();
    exp(1, S_EXREGDST, 1);
    exp(1, S_EXALUOP, 2);
    exp(3, S_WBRW, 1);
    exp(3, S_WBREG, 10);
    tick();
    drain(4);

    cur_tag = "loaduse_r0";
    lw(5'd1, 5'd0);
    tick();
    rtype(5'd0, 5'd0, 5'd11);
    exp(0, S_STALL, 0);
    exp(1, S_STALL, 0);
    exp(1, S_EXREGDST, 1);
    exp(3, S_WBREG, 11);
    tick();
    drain(4);

    cur_tag = "beq_taken";
    beq(5'd1, 5'd2);
    exp(1, S_EXALUOP, 1);
    tick();
    bus.ExZero = 1'b1;
    sw(5'd3, 5'd4);
    exp(0, S_PCSRC, 0);
    tick();
    bus.ExZero = 1'b0;
    rtype(5'd5, 5'd6, 5'd12);
    exp(0, S_PCSRC, 1);
    exp(0, S_FLUSH, 1);
    exp(0, S_STALL, 0);
    exp(1, S_PCSRC, 0);
    exp(1, S_FLUSH, 0);
    exp(1, S_MEMWR, 0);
    exp(1, S_EXREGDST, 0);
    exp(1, S_EXALUOP, 0);
    exp(2, S_WBRW, 0);
    exp(3, S_WBRW, 0);
    tick();
    drain(4);

    cur_tag = "beq_not_taken";
    beq(5'd1, 5'd2);
    tick();
    bus.ExZero = 1'b0;
    sw(5'd3, 5'd4);
    tick();
    rtype(5'd5, 5'd6, 5'd13);
    exp(0, S_PCSRC, 0);
    exp(0, S_FLUSH, 0);
    exp(1, S_MEMWR, 1);
    exp(1, S_EXREGDST, 1);
    exp(3, S_WBRW, 1);
    exp(3, S_WBREG, 13);
    tick();
    drain(4);

    cur_tag = "flush_vs_stall";
    beq(5'd1, 5'd2);
    tick();
    bus.ExZero = 1'b1;
    lw(5'd1, 5'd8);
    exp(0, S_STALL, 0);
    tick();
    bus.ExZero = 1'b0;
    rtype(5'd8, 5'd3, 5'd14);
    exp(0, S_PCSRC, 1);
    exp(0, S_FLUSH, 1);
    exp(0, S_STALL, 0);
    exp(1, S_EXREGDST, 0);
    exp(1, S_EXALUOP, 0);
    exp(1, S_MEMRD, 0);
    exp(1, S_PCSRC, 0);
    exp(2, S_WBRW, 0);
    tick();
    drain(4);

    cur_tag = "reset_mid";
    lw(5'd1, 5'd7);
    tick();
    nop();
    tick();
    exp(0, S_MEMRD, 1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    exp_all_zero(0);
    exp(1, S_WBRW, 0);
    exp(2, S_WBRW, 0);
    tick();
    drain(4);

    cur_tag = "final";
    repeat (3) tick();
    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s/%s: never checked",
                 sb[i].tag, sb[i].id.name());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
- Receive end of the main decoder's control bundle (RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite) in the 5-stage MIPS pipeline.
- Registers the bundle through ID/EX, EX/MEM and MEM/WB and delivers each signal to the stage that consumes it.
- Detects load-use hazards, inserts bubbles, resolves branches in MEM and flushes younger stages.

Parameters:
REG_W, 5, register-address width
ALUOP_W, 2, ALUOp width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous, active-high reset
RegDst  in  1  ID-stage control from decoder
Branch  in  1  ID-stage control
MemRead  in  1  ID-stage control
MemtoReg  in  1  ID-stage control
ALUOp  in  ALUOP_W  ID-stage control
MemWrite  in  1  ID-stage control
ALUSrc  in  1  ID-stage control
RegWrite  in  1  ID-stage control
IdRs  in  REG_W  rs field of instruction in ID
IdRt  in  REG_W  rt field of instruction in ID
IdRd  in  REG_W  rd field of instruction in ID
ExZero  in  1  ALU zero flag from EX
ExRegDst  out  1  EX destination mux select
ExALUOp  out  ALUOP_W  to ALU control
ExALUSrc  out  1  ALU B mux select
MemMemRead  out  1  data-memory read enable
MemMemWrite  out  1  data-memory write enable
PCSrc  out  1  branch taken (MEM)
WbRegWrite  out  1  register-file write enable
WbMemtoReg  out  1  writeback mux select
WbWriteReg  out  REG_W  register-file write address
Stall  out  1  hold PC and IF/ID
FlushIfId  out  1  zero IF/ID instruction

Behaviour:
- Synchronous active-high reset: Rst=1 at a rising edge clears all stage registers (controls, addresses, zero flag) to 0.
- Reset state of outputs: all Ex*/Mem*/Wb* outputs are 0, and PCSrc, Stall and FlushIfId are 0.
- Rst has priority over stall and flush. Asserting Rst mid-operation discards all in-flight controls.
- ID/EX stage:
  - Captures all 8 controls plus IdRt and IdRd each cycle.
  - Bubble: loads all-zero controls when Stall=1 or PCSrc=1. Address fields are don't-care in a bubble.
- EX stage:
  - DestEx = ExRegDst ? IdEx.Rd : IdEx.Rt (combinational).
  - EX/MEM captures Branch, MemRead, MemWrite, MemtoReg, RegWrite, DestEx and ExZero.
  - EX/MEM loads zero controls when PCSrc=1 (flush of the wrong-path instruction in EX).
- MEM stage:
  - PCSrc = ExMem.Branch & ExMem.Zero (combinational).
  - MEM/WB captures MemtoReg, RegWrite and Dest.
  - MEM/WB is never flushed, so the branch itself commits.
- Latency:
  - An ID-stage control appears on its Ex* output 1 cycle later, Mem* 2 cycles later, Wb* 3 cycles later.
  - ALUOp, ALUSrc and RegDst are visible only at EX. MemRead and MemWrite are visible only at MEM.
- Load-use hazard (combinational):
  - Stall = IdEx.MemRead & (IdEx.Rt != 0) & ((IdEx.Rt == IdRs) | (IdEx.Rt == IdRt)) & ~PCSrc.
  - Exactly one bubble per load-use pair: after the bubble, IdEx.MemRead = 0, so Stall drops.
- Flush: FlushIfId = PCSrc.
- Simultaneous events: load-use and PCSrc in the same cycle → flush wins. Stall=0, and the ID/EX bubble is inserted anyway.
- Back-to-back branches: a second branch is already flushed, so it never raises PCSrc.
- No forwarding logic in this block.

Test Plan:
1. Reset: Rst=1 for 2 cycles with R-type controls applied → all outputs 0. After release, first R-type (RegDst=1, RegWrite=1, ALUOp=10, IdRd=5) → ExRegDst=1 and ExALUOp=10 at +1; WbRegWrite=1 and WbWriteReg=5 at +3.
2. lw (MemRead=1, MemtoReg=1, RegWrite=1, ALUSrc=1, IdRt=8) followed by sw → MemMemRead=1 at +2, WbMemtoReg=1 and WbWriteReg=8 at +3, MemMemWrite=1 for the sw one cycle after the lw's.
3. Load-use: lw with IdRt=8, then R-type with IdRs=8 → Stall=1 for exactly 1 cycle and ID/EX all zero next cycle. Repeat with IdRt=0 → Stall never asserts.
4. beq (Branch=1, ALUOp=01), ExZero=1 in its EX cycle → PCSrc=1 and FlushIfId=1 for 1 cycle 2 cycles after ID. Younger instructions in ID/EX and EX/MEM produce no MemMemWrite and no WbRegWrite. Repeat with ExZero=0 → PCSrc stays 0 and younger instructions commit.
5. Load-use hazard coinciding with PCSrc=1 → Stall=0, FlushIfId=1, ID/EX bubble inserted.
6. Rst asserted while a lw is in EX/MEM → next cycle all outputs 0, and no WbRegWrite ever asserts for that lw.
